// File: rtl/ext_int_source_pkg.sv
// ext_int_source_pkg
//   Shared definitions for the external interrupt-source responder:
//   FSM state encoding, the default acknowledge word address (same constant
//   the CPU's interrupt-ack logic writes), and the ack-write decode helper.
package ext_int_source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ASSERT = 2'd2,
    ST_GAP    = 2'd3
  } int_state_e;

  localparam logic [31:0] ACK_ADDR_DEFAULT = 32'h0000_7F20;

  // A write to any byte of the acknowledge word; the byte offset is ignored.
  function automatic logic is_ack_write(input logic [31:0] addr,
                                        input logic [3:0]  byteen,
                                        input logic [31:0] ack_addr);
    return (byteen != 4'b0000) && ((addr & ~32'h3) == (ack_addr & ~32'h3));
  endfunction

endpackage

// File: rtl/ext_int_source_trigger_gen.sv
// int_trigger_gen
//   Produces a one-cycle trigger pulse for the interrupt source.
//   mode 0: rising match of the CPU PC against trig_pc (one pulse per visit).
//   mode 1: free-running period counter, pulse when it reaches period-1.
//   Ports:
//     clk, reset  clock and synchronous active-high reset
//     mode        0 = PC match, 1 = periodic
//     trig_pc     PC to match in mode 0
//     period      period in mode 1 (0 = disabled)
//     en          gates the trigger output only
//     pc          CPU macroscopic PC
//     trig        one-cycle trigger pulse (combinational)
module int_trigger_gen
  import ext_int_source_pkg::*;
#(
  parameter int unsigned DELAY_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [31:0]        trig_pc,
  input  logic [DELAY_W-1:0] period,
  input  logic               en,
  input  logic [31:0]        pc,
  output logic               trig
);

  localparam logic [DELAY_W-1:0] CNT_ONE = DELAY_W'(1);

  logic [31:0]        prev_pc;
  logic [DELAY_W-1:0] pcnt;
  logic               period_on;
  logic               period_hit;
  logic               pc_hit;

  always_comb begin
    period_on  = mode && (period != '0);
    // >= rather than == so a period shortened below the running count
    // still wraps on the next cycle instead of running all the way around.
    period_hit = period_on && (pcnt >= (period - CNT_ONE));
    pc_hit     = !mode && (pc == trig_pc) && (prev_pc != trig_pc);
    trig       = en && (pc_hit || period_hit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_pc <= '0;
      pcnt    <= '0;
    end else begin
      prev_pc <= pc;
      if (!period_on || period_hit) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/ext_int_source.sv
// ext_int_source
//   Interrupt-source responder driving the CPU's external interrupt input.
//   A trigger (PC match or periodic) raises a level request, optionally after
//   a delay; it is held until the handler writes the acknowledge word.
//   Triggers arriving while a request is in flight are queued in 'pending'
//   and replayed after a one-cycle low gap so CP0 sees a fresh edge.
//   Ports:
//     clk, reset      clock and synchronous active-high reset
//     cfg_we          load cfg_* into the configuration registers
//     cfg_mode        0 = PC-match trigger, 1 = periodic trigger
//     cfg_pc          trigger PC (mode 0)
//     cfg_delay       trigger-to-assert delay (mode 0) / period (mode 1)
//     cfg_en          global trigger enable
//     macroscopic_pc  CPU macroscopic PC
//     m_int_addr      interrupt-ack write address
//     m_int_byteen    interrupt-ack byte enables (any set = write)
//     interrupt       level interrupt request
//     pending         triggers queued behind the current request
//     irq_count       acknowledged requests, wraps at 16 bits
module ext_int_source
  import ext_int_source_pkg::*;
#(
  parameter logic [31:0] ACK_ADDR = ACK_ADDR_DEFAULT,
  parameter int unsigned DELAY_W  = 16,
  parameter int unsigned PEND_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic               cfg_mode,
  input  logic [31:0]        cfg_pc,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic               cfg_en,
  input  logic [31:0]        macroscopic_pc,
  input  logic [31:0]        m_int_addr,
  input  logic [3:0]         m_int_byteen,
  output logic               interrupt,
  output logic [PEND_W-1:0]  pending,
  output logic [15:0]        irq_count
);

  localparam logic [DELAY_W-1:0] DCNT_ONE = DELAY_W'(1);
  localparam logic [PEND_W-1:0]  PEND_ONE = PEND_W'(1);
  localparam logic [PEND_W-1:0]  PEND_MAX = '1;

  // Configuration registers
  logic               cfg_mode_r;
  logic [31:0]        cfg_pc_r;
  logic [DELAY_W-1:0] cfg_delay_r;
  logic               cfg_en_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_mode_r  <= 1'b0;
      cfg_pc_r    <= '0;
      cfg_delay_r <= '0;
      cfg_en_r    <= 1'b0;
    end else if (cfg_we) begin
      cfg_mode_r  <= cfg_mode;
      cfg_pc_r    <= cfg_pc;
      cfg_delay_r <= cfg_delay;
      cfg_en_r    <= cfg_en;
    end
  end

  // Trigger generation
  logic trig;

  int_trigger_gen #(
    .DELAY_W (DELAY_W)
  ) u_trigger_gen (
    .clk     (clk),
    .reset   (reset),
    .mode    (cfg_mode_r),
    .trig_pc (cfg_pc_r),
    .period  (cfg_delay_r),
    .en      (cfg_en_r),
    .pc      (macroscopic_pc),
    .trig    (trig)
  );

  // Request FSM
  int_state_e         state, state_nxt;
  logic [DELAY_W-1:0] dcnt, dcnt_nxt;
  logic [PEND_W-1:0]  pending_nxt;
  logic [PEND_W-1:0]  pend_eff;
  logic [15:0]        irq_count_nxt;
  logic               ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      dcnt      <= '0;
      pending   <= '0;
      irq_count <= '0;
      interrupt <= 1'b0;
    end else begin
      state     <= state_nxt;
      dcnt      <= dcnt_nxt;
      pending   <= pending_nxt;
      irq_count <= irq_count_nxt;
      interrupt <= (state_nxt == ST_ASSERT);
    end
  end

  always_comb begin
    state_nxt     = state;
    dcnt_nxt      = dcnt;
    irq_count_nxt = irq_count;
    ack           = is_ack_write(m_int_addr, m_int_byteen, ACK_ADDR);

    // Any trigger while a request is in flight is queued first; a saturated
    // queue silently drops it. An ack in the same cycle then consumes from
    // the updated queue, so trig+ack with an empty queue still yields a gap.
    pend_eff = pending;
    if (trig && (state != ST_IDLE) && (pending != PEND_MAX)) begin
      pend_eff = pending + PEND_ONE;
    end
    pending_nxt = pend_eff;

    case (state)
      ST_IDLE: begin
        if (trig) begin
          if (!cfg_mode_r && (cfg_delay_r != '0)) begin
            state_nxt = ST_DELAY;
            dcnt_nxt  = cfg_delay_r;
          end else begin
            state_nxt = ST_ASSERT;
          end
        end
      end
      ST_DELAY: begin
        if (dcnt <= DCNT_ONE) begin
          state_nxt = ST_ASSERT;
          dcnt_nxt  = '0;
        end else begin
          dcnt_nxt  = dcnt - DCNT_ONE;
        end
      end
      ST_ASSERT: begin
        if (ack) begin
          irq_count_nxt = irq_count + 16'd1;
          if (pend_eff != '0) begin
            state_nxt   = ST_GAP;
            pending_nxt = pend_eff - PEND_ONE;
          end else begin
            state_nxt   = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        state_nxt = ST_ASSERT;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ext_int_source.sv
// tb_ext_int_source
//   Directed bench for ext_int_source. A timestamp-based reference model
//   (busy flag, rise edge number, queue depth, ack count) predicts the
//   outputs every cycle; literal expectations pin the key scenarios.
module tb_ext_int_source;

  logic        clk;
  logic        reset;
  logic        cfg_we;
  logic        cfg_mode;
  logic [31:0] cfg_pc;
  logic [15:0] cfg_delay;
  logic        cfg_en;
  logic [31:0] macroscopic_pc;
  logic [31:0] m_int_addr;
  logic [3:0]  m_int_byteen;
  logic        interrupt;
  logic [2:0]  pending;
  logic [15:0] irq_count;

  int checks   = 0;
  int failures = 0;

  ext_int_source #(
    .ACK_ADDR (32'h0000_7F20),
    .DELAY_W  (16),
    .PEND_W   (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_we         (cfg_we),
    .cfg_mode       (cfg_mode),
    .cfg_pc         (cfg_pc),
    .cfg_delay      (cfg_delay),
    .cfg_en         (cfg_en),
    .macroscopic_pc (macroscopic_pc),
    .m_int_addr     (m_int_addr),
    .m_int_byteen   (m_int_byteen),
    .interrupt      (interrupt),
    .pending        (pending),
    .irq_count      (irq_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int PEND_LIMIT = 7;

  int unsigned edge_no = 0;      // number of the most recent rising edge
  bit          model_valid = 0;
  bit          m_busy;           // a request is in flight (waiting, high or gap)
  int unsigned m_rise;           // edge after which interrupt is high
  int          m_pend;
  logic [15:0] m_count;
  bit          mc_mode, mc_en;
  logic [31:0] mc_pc;
  int          mc_delay;
  logic [31:0] m_prev_pc;
  int          m_ticks;          // cycles since the period counter was enabled

  always @(posedge clk) begin
    int unsigned cur;
    bit m_trig, m_ack, m_level;
    cur = edge_no + 1;
    if (reset) begin
      model_valid = 1;
      m_busy = 0; m_rise = 0; m_pend = 0; m_count = '0;
      mc_mode = 0; mc_en = 0; mc_pc = '0; mc_delay = 0;
      m_prev_pc = '0; m_ticks = 0;
    end else begin
      m_level = m_busy && (edge_no >= m_rise);
      m_trig = 0;
      if (mc_en) begin
        if (!mc_mode) m_trig = (macroscopic_pc == mc_pc) && (m_prev_pc != mc_pc);
        else if (mc_delay != 0) m_trig = (m_ticks % mc_delay) == (mc_delay - 1);
      end
      if (mc_mode && mc_delay != 0) m_ticks++;
      else m_ticks = 0;
      m_ack = (m_int_byteen != 4'b0000) && ((m_int_addr >> 2) == (32'h7F20 >> 2));

      if (!m_busy) begin
        if (m_trig) begin
          m_busy = 1;
          m_rise = cur + ((!mc_mode && mc_delay > 0) ? mc_delay : 0);
        end
      end else begin
        if (m_trig && m_pend < PEND_LIMIT) m_pend++;
        if (m_ack && m_level) begin
          m_count = m_count + 16'd1;
          if (m_pend > 0) begin
            m_pend--;
            m_rise = cur + 1;
          end else begin
            m_busy = 0;
          end
        end
      end

      if (cfg_we) begin
        mc_mode = cfg_mode; mc_pc = cfg_pc; mc_delay = int'(cfg_delay); mc_en = cfg_en;
      end
      m_prev_pc = macroscopic_pc;
    end
    edge_no = cur;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("cmp_interrupt", 32'(interrupt), 32'(m_busy && (edge_no >= m_rise)));
      check("cmp_pending",   32'(pending),   32'(m_pend));
      check("cmp_irq_count", 32'(irq_count), 32'(m_count));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cfg_load(input logic mode, input logic [31:0] pc,
                          input logic [15:0] delay, input logic en);
    cfg_we = 1'b1; cfg_mode = mode; cfg_pc = pc; cfg_delay = delay; cfg_en = en;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic ack_drive(input logic [31:0] addr, input logic [3:0] be);
    m_int_addr = addr; m_int_byteen = be;
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_mode = 1'b0; cfg_pc = '0; cfg_delay = '0;
    cfg_en = 1'b0; macroscopic_pc = '0; m_int_addr = '0; m_int_byteen = '0;
    repeat (3) @(negedge clk);
    check("reset_int", 32'(interrupt), 32'd0);
    check("reset_pend", 32'(pending), 32'd0);
    check("reset_count", 32'(irq_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // mode 0, delay 0: assert on the next edge, ack drops it
    cfg_load(1'b0, 32'h3010, 16'd0, 1'b1);
    macroscopic_pc = 32'h3010;
    @(negedge clk);
    check("d0_rise", 32'(interrupt), 32'd1);
    ack_drive(32'h7F20, 4'b0001);
    @(negedge clk);
    check("d0_ack_int", 32'(interrupt), 32'd0);
    check("d0_ack_count", 32'(irq_count), 32'd1);
    ack_drive('0, 4'b0000);
    macroscopic_pc = '0;

    // mode 0, delay 5: rise 6 edges after match, PC held 3 cycles = one trigger
    cfg_load(1'b0, 32'h3010, 16'd5, 1'b1);
    macroscopic_pc = 32'h3010;
    repeat (3) @(negedge clk);
    macroscopic_pc = '0;
    repeat (2) @(negedge clk);
    check("d5_low_at_5", 32'(interrupt), 32'd0);
    @(negedge clk);
    check("d5_high_at_6", 32'(interrupt), 32'd1);
    check("d5_pend", 32'(pending), 32'd0);
    ack_drive(32'h7F20, 4'b1000);
    @(negedge clk);
    check("d5_ack_count", 32'(irq_count), 32'd2);
    ack_drive('0, 4'b0000);

    // ack while idle is ignored
    ack_drive(32'h7F20, 4'b0001);
    @(negedge clk);
    check("idle_ack_count", 32'(irq_count), 32'd2);
    ack_drive('0, 4'b0000);

    // wrong address / no byte enables do not acknowledge; byte offset ignored
    cfg_load(1'b0, 32'h3010, 16'd0, 1'b1);
    macroscopic_pc = 32'h3010;
    @(negedge clk);
    ack_drive(32'h7F24, 4'b0001);
    @(negedge clk);
    check("bad_addr_int", 32'(interrupt), 32'd1);
    check("bad_addr_count", 32'(irq_count), 32'd2);
    ack_drive(32'h7F20, 4'b0000);
    @(negedge clk);
    check("no_be_int", 32'(interrupt), 32'd1);
    ack_drive(32'h7F22, 4'b0100);
    @(negedge clk);
    check("offset_ack_int", 32'(interrupt), 32'd0);
    check("offset_ack_count", 32'(irq_count), 32'd3);
    ack_drive('0, 4'b0000);
    macroscopic_pc = '0;

    // trig and ack together in ASSERT: gap, then high again, queue unchanged
    @(negedge clk);
    macroscopic_pc = 32'h3010;
    @(negedge clk);
    macroscopic_pc = '0;
    @(negedge clk);
    macroscopic_pc = 32'h3010;
    ack_drive(32'h7F20, 4'b0001);
    @(negedge clk);
    check("tack_gap_int", 32'(interrupt), 32'd0);
    check("tack_pend", 32'(pending), 32'd0);
    check("tack_count", 32'(irq_count), 32'd4);
    ack_drive('0, 4'b0000);
    @(negedge clk);
    check("tack_reassert", 32'(interrupt), 32'd1);
    ack_drive(32'h7F20, 4'b0001);
    @(negedge clk);
    check("tack_final_count", 32'(irq_count), 32'd5);
    ack_drive('0, 4'b0000);
    macroscopic_pc = '0;

    // trigger during the delay is queued
    cfg_load(1'b0, 32'h3010, 16'd3, 1'b1);
    macroscopic_pc = 32'h3010;
    @(negedge clk);
    macroscopic_pc = '0;
    @(negedge clk);
    macroscopic_pc = 32'h3010;
    @(negedge clk);
    check("dly_q_pend", 32'(pending), 32'd1);
    check("dly_q_low", 32'(interrupt), 32'd0);
    @(negedge clk);
    check("dly_q_high", 32'(interrupt), 32'd1);
    ack_drive(32'h7F20, 4'b0001);
    @(negedge clk);
    ack_drive('0, 4'b0000);
    @(negedge clk);
    ack_drive(32'h7F20, 4'b0001);
    @(negedge clk);
    check("dly_q_count", 32'(irq_count), 32'd7);
    ack_drive('0, 4'b0000);
    macroscopic_pc = '0;

    // mode 1, period 10: queue fills to 7 and saturates
    cfg_load(1'b1, 32'h0, 16'd10, 1'b1);
    repeat (35) @(negedge clk);
    check("per_pend_2", 32'(pending), 32'd2);
    check("per_int", 32'(interrupt), 32'd1);
    repeat (65) @(negedge clk);
    check("per_pend_sat", 32'(pending), 32'd7);
    ack_drive(32'h7F20, 4'b0001);
    @(negedge clk);
    check("per_gap_int", 32'(interrupt), 32'd0);
    check("per_gap_pend", 32'(pending), 32'd6);
    check("per_gap_count", 32'(irq_count), 32'd8);
    ack_drive('0, 4'b0000);
    @(negedge clk);
    check("per_reassert", 32'(interrupt), 32'd1);
    cfg_load(1'b1, 32'h0, 16'd10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      ack_drive(32'h7F20, 4'b0001);
      @(negedge clk);
      ack_drive('0, 4'b0000);
      @(negedge clk);
    end
    check("per_pend_3", 32'(pending), 32'd3);
    check("per_int_3", 32'(interrupt), 32'd1);
    check("per_count_11", 32'(irq_count), 32'd11);

    // reset mid-request discards everything
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_int", 32'(interrupt), 32'd0);
    check("rst_mid_pend", 32'(pending), 32'd0);
    check("rst_mid_count", 32'(irq_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // disabling during a delay lets it complete; delay change does not restart it
    cfg_load(1'b0, 32'h3010, 16'd2, 1'b1);
    macroscopic_pc = 32'h3010;
    @(negedge clk);
    cfg_load(1'b0, 32'h3010, 16'd7, 1'b0);
    check("dis_low", 32'(interrupt), 32'd0);
    @(negedge clk);
    check("dis_high", 32'(interrupt), 32'd1);
    ack_drive(32'h7F20, 4'b0001);
    @(negedge clk);
    ack_drive('0, 4'b0000);
    macroscopic_pc = '0;
    @(negedge clk);
    macroscopic_pc = 32'h3010;
    repeat (3) @(negedge clk);
    check("dis_no_trig", 32'(interrupt), 32'd0);
    check("dis_count", 32'(irq_count), 32'd1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
